// File: rtl/crc_frame_appender.sv
// Byte-stream framer: forwards sop/eop framed bytes and appends a CRC trailer, LSB first.
// Optional macro CRC_FRAME_STATS_EN adds frame_cnt_o, a count of frames fully taken downstream.
module crc_frame_appender #(
  parameter int                  CRC_SIZE = 16,
  parameter logic [CRC_SIZE-1:0] POLY     = 16'h8005,
  parameter logic [CRC_SIZE-1:0] INIT     = 16'h0000,
  parameter bit                  REF_IN   = 1'b1,
  parameter bit                  REF_OUT  = 1'b1,
  parameter logic [CRC_SIZE-1:0] XOR_OUT  = 16'hFFFF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       s_valid_i,
  output logic       s_ready_o,
  input  logic [7:0] s_data_i,
  input  logic       s_sop_i,
  input  logic       s_eop_i,
  output logic       m_valid_o,
  input  logic       m_ready_i,
  output logic [7:0] m_data_o,
  output logic       m_sop_o,
  output logic       m_eop_o,
`ifdef CRC_FRAME_STATS_EN
  output logic [15:0] frame_cnt_o,
`endif
  output logic       proto_err_o
);

  localparam int NBYTES = CRC_SIZE / 8;

  typedef enum logic [1:0] {IDLE, DATA, CRC} state_t;

  state_t              state, state_d;
  logic [CRC_SIZE-1:0] crc_p0, crc_d;
  logic [1:0]          byte_idx, idx_d;
  logic                adv, acc, load;
  logic [7:0]          data_d;
  logic                sop_d, eop_d, perr_d;
  logic [CRC_SIZE-1:0] crc_out;

  // Register kept in non-reflected form; REF_IN only picks the bit feed order.
  function automatic logic [CRC_SIZE-1:0] crc_byte(input logic [CRC_SIZE-1:0] c,
                                                   input logic [7:0] b);
    logic [CRC_SIZE-1:0] r;
    logic                fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[CRC_SIZE-1] ^ (REF_IN ? b[i] : b[7-i]);
      r  = {r[CRC_SIZE-2:0], 1'b0};
      if (fb) r = r ^ POLY;
    end
    return r;
  endfunction

  function automatic logic [CRC_SIZE-1:0] crc_final(input logic [CRC_SIZE-1:0] c);
    logic [CRC_SIZE-1:0] r;
    for (int i = 0; i < CRC_SIZE; i++) r[i] = c[CRC_SIZE-1-i];
    return (REF_OUT ? r : c) ^ XOR_OUT;
  endfunction

  assign adv       = !m_valid_o || m_ready_i;
  assign s_ready_o = adv && (state != CRC);
  assign acc       = s_valid_i && s_ready_o;
  assign crc_out   = crc_final(crc_p0);

  always_comb begin
    state_d = state;
    crc_d   = crc_p0;
    idx_d   = byte_idx;
    load    = 1'b0;
    data_d  = s_data_i;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    perr_d  = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          if (s_sop_i) begin
            load    = 1'b1;
            sop_d   = 1'b1;
            crc_d   = crc_byte(INIT, s_data_i);
            idx_d   = 2'd0;
            state_d = s_eop_i ? CRC : DATA;
          end else begin
            perr_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (acc) begin
          load   = 1'b1;
          crc_d  = crc_byte(crc_p0, s_data_i);
          perr_d = s_sop_i;
          if (s_eop_i) begin
            idx_d   = 2'd0;
            state_d = CRC;
          end
        end
      end
      CRC: begin
        if (adv) begin
          load   = 1'b1;
          data_d = 8'(crc_out >> (8 * byte_idx));
          if (byte_idx == 2'(NBYTES - 1)) begin
            eop_d   = 1'b1;
            crc_d   = INIT;
            state_d = IDLE;
          end else begin
            idx_d = byte_idx + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output stage p0: single register loaded only when the downstream slot is free.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      crc_p0      <= INIT;
      byte_idx    <= 2'd0;
      m_valid_o   <= 1'b0;
      m_sop_o     <= 1'b0;
      m_eop_o     <= 1'b0;
      m_data_o    <= 8'h00;
      proto_err_o <= 1'b0;
    end else begin
      state       <= state_d;
      crc_p0      <= crc_d;
      byte_idx    <= idx_d;
      proto_err_o <= perr_d;
      if (adv) begin
        m_valid_o <= load;
        m_sop_o   <= sop_d;
        m_eop_o   <= eop_d;
        if (load) m_data_o <= data_d;
      end
    end
  end

`ifdef CRC_FRAME_STATS_EN
  logic [15:0] frame_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) frame_cnt <= 16'h0000;
    else if (m_valid_o && m_ready_i && m_eop_o) frame_cnt <= frame_cnt + 16'h0001;
  end

  assign frame_cnt_o = frame_cnt;
`endif

endmodule

// File: tb/tb_crc_frame_appender.sv
// Scoreboard bench for crc_frame_appender using CRC-16/MAXIM check vectors.
module tb_crc_frame_appender;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'h00;
  logic       s_sop = 1'b0;
  logic       s_eop = 1'b0;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       m_sop;
  logic       m_eop;
  logic       proto_err;
`ifdef CRC_FRAME_STATS_EN
  logic [15:0] frame_cnt;
`endif

  int         tests = 0;
  int         fails = 0;
  int         perr_cnt = 0;
  bit         rand_rdy = 1'b0;
  bit         in_crc = 1'b0;
  bit         hold_vld = 1'b0;
  logic [9:0] hold_val;
  logic [9:0] exp_q[$];

  crc_frame_appender dut (
    .clk_i(clk), .rst_i(rst),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
    .s_sop_i(s_sop), .s_eop_i(s_eop),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data),
    .m_sop_o(m_sop), .m_eop_o(m_eop),
`ifdef CRC_FRAME_STATS_EN
    .frame_cnt_o(frame_cnt),
`endif
    .proto_err_o(proto_err)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops the scoreboard on every handshake, checks stall stability and CRC-phase backpressure.
  always @(negedge clk) begin
    logic [9:0] e;
    if (m_valid && m_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: got sop=%b eop=%b data=%h, none expected", m_sop, m_eop, m_data);
      end else begin
        e = exp_q.pop_front();
        if ({m_sop, m_eop, m_data} !== e)
          begin
            fails++;
            $display("FAIL out_byte: got sop=%b eop=%b data=%h, want sop=%b eop=%b data=%h",
                     m_sop, m_eop, m_data, e[9], e[8], e[7:0]);
          end
      end
    end
    if (hold_vld && !rst) begin
      tests++;
      if ({m_valid, m_sop, m_eop, m_data} !== {1'b1, hold_val}) begin
        fails++;
        $display("FAIL stall_stable: got vld=%b %h, want vld=1 %h", m_valid, {m_sop, m_eop, m_data}, hold_val);
      end
    end
    hold_vld = m_valid && !m_ready && !rst;
    hold_val = {m_sop, m_eop, m_data};
    if (in_crc) begin
      if (m_valid && m_eop) in_crc = 1'b0;
      else begin
        tests++;
        if (s_ready !== 1'b0) begin
          fails++;
          $display("FAIL crc_ready: got s_ready=%b, want 0", s_ready);
        end
      end
    end
    if (proto_err === 1'b1) perr_cnt++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic s, input logic e);
    exp_q.push_back({s, e, d});
  endtask

  task automatic send(input logic [7:0] d, input logic s, input logic e, output int waits);
    logic got;
    int   n;
    s_valid = 1'b1; s_data = d; s_sop = s; s_eop = e;
    waits = 0; n = 0;
    do begin
      @(negedge clk);
      got = s_ready;
      if (!got) waits++;
      @(posedge clk);
      #1;
      n++;
    end while (!got && n < 200);
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
    if (!got) begin
      tests++; fails++;
      $display("FAIL send_timeout: byte %h not accepted in 200 cycles, want accepted", d);
    end else if (e) in_crc = 1'b1;
  endtask

  // "123456789" -> payload then C2 44; extra_sop marks one mid-frame byte with sop as well.
  task automatic frame9(input int extra_sop, output int first_wait);
    int w;
    for (int i = 0; i < 9; i++) push(8'h31 + 8'(i), i == 0, 1'b0);
    push(8'hC2, 1'b0, 1'b0);
    push(8'h44, 1'b0, 1'b1);
    first_wait = 0;
    for (int i = 0; i < 9; i++) begin
      send(8'h31 + 8'(i), (i == 0) || (i == extra_sop), i == 8, w);
      if (i == 0) first_wait = w;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d bytes still pending, want 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int w, p0;
    #2 rst = 1'b1;
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_sop", 32'(m_sop), 32'd0);
    check("rst_m_eop", 32'(m_eop), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_proto_err", 32'(proto_err), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    frame9(-1, w);
    drain();

    p0 = perr_cnt;
    push(8'h00, 1'b1, 1'b0); push(8'hFF, 1'b0, 1'b0); push(8'hFF, 1'b0, 1'b1);
    send(8'h00, 1'b1, 1'b1, w);
    drain();
    check("single_no_perr", 32'(perr_cnt), 32'(p0));

    rand_rdy = 1'b1;
    frame9(-1, w);
    drain();
    rand_rdy = 1'b0;
    repeat (2) @(posedge clk); #1;

    p0 = perr_cnt;
    send(8'hAA, 1'b0, 1'b0, w);
    drain();
    check("nosop_perr_pulse", 32'(perr_cnt), 32'(p0 + 1));
    frame9(-1, w);
    drain();
    check("after_nosop_perr", 32'(perr_cnt), 32'(p0 + 1));

    p0 = perr_cnt;
    frame9(4, w);
    drain();
    check("sop_in_data_perr", 32'(perr_cnt), 32'(p0 + 1));

    push(8'h31, 1'b1, 1'b0); push(8'h32, 1'b0, 1'b0); push(8'h33, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send(8'h31 + 8'(i), i == 0, 1'b0, w);
    rst = 1'b1;
    #1;
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    frame9(-1, w);
    drain();

    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    frame9(-1, w);
    frame9(-1, w);
    check("b2b_gap_2", 32'(w), 32'd2);
    frame9(-1, w);
    check("b2b_gap_3", 32'(w), 32'd2);
    drain();
`ifdef CRC_FRAME_STATS_EN
    check("frame_cnt_3", 32'(frame_cnt), 32'd3);
    @(negedge clk) force dut.frame_cnt = 16'hFFFF;
    @(negedge clk) release dut.frame_cnt;
    #1;
    check("frame_cnt_preload", 32'(frame_cnt), 32'h0000FFFF);
    push(8'h00, 1'b1, 1'b0); push(8'hFF, 1'b0, 1'b0); push(8'hFF, 1'b0, 1'b1);
    send(8'h00, 1'b1, 1'b1, w);
    drain();
    check("frame_cnt_wrap", 32'(frame_cnt), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
